// File: rtl/control_unit.sv
// control_unit: multicycle MIPS-subset controller; one FSM state per cycle,
// with datapath selects and write enables decoded from the state and the IR fields.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Overflow,
  input  logic       Menor,
  input  logic       flag_eq,
  output logic       PC_write,
  output logic       A_write,
  output logic       B_write,
  output logic       EPC_write,
  output logic       HI_write,
  output logic       LO_write,
  output logic       FlagRegWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [2:0] Seletor,
  output logic       seletor_ulaA,
  output logic [1:0] seletor_ulaB,
  output logic [2:0] ShiftOP,
  output logic       SrInputSrc,
  output logic [1:0] SrNSrc,
  output logic [2:0] RegDst,
  output logic [3:0] MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] IorD,
  output logic [4:0] state
);
  typedef enum logic [4:0] {
    S_RST, S_F1, S_F2, S_F3, S_DEC, S_EXEC, S_SH1, S_SH2, S_SH3,
    S_BR1, S_BR2, S_LW1, S_LW2, S_LW3, S_SW, S_EXC1, S_EXC2, S_EXC3
  } state_t;
  state_t state_q, state_d;
  logic   cause_q, cause_d;
  logic   unused;
  assign unused = Menor;
  logic r, is_add, is_sub, is_and, is_slt, is_sll, is_srl, is_sra, is_mfhi, is_mflo, is_jr;
  logic is_addi, is_beq, is_bne, is_lw, is_sw, is_lui, is_j, is_jal, is_exec, trap;
  assign r       = opcode == 6'h00;
  assign is_add  = r && funct == 6'h20;
  assign is_sub  = r && funct == 6'h22;
  assign is_and  = r && funct == 6'h24;
  assign is_slt  = r && funct == 6'h2a;
  assign is_sll  = r && funct == 6'h00;
  assign is_srl  = r && funct == 6'h02;
  assign is_sra  = r && funct == 6'h03;
  assign is_mfhi = r && funct == 6'h10;
  assign is_mflo = r && funct == 6'h12;
  assign is_jr   = r && funct == 6'h08;
  assign is_addi = opcode == 6'h08;
  assign is_beq  = opcode == 6'h04;
  assign is_bne  = opcode == 6'h05;
  assign is_lw   = opcode == 6'h23;
  assign is_sw   = opcode == 6'h2b;
  assign is_lui  = opcode == 6'h0f;
  assign is_j    = opcode == 6'h02;
  assign is_jal  = opcode == 6'h03;
  assign is_exec = is_add | is_sub | is_and | is_slt | is_mfhi | is_mflo | is_jr
                 | is_addi | is_lui | is_j | is_jal;
  // and is excluded: only signed arithmetic traps on overflow
  assign trap    = Overflow & (is_add | is_sub | is_addi);
  assign state   = state_q;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    PC_write = 1'b0; A_write = 1'b0; B_write = 1'b0; EPC_write = 1'b0;
    HI_write = 1'b0; LO_write = 1'b0; FlagRegWrite = 1'b0; IRWrite = 1'b0;
    RegWrite = 1'b0; MemWrite = 1'b0;
    Seletor = 3'b000; seletor_ulaA = 1'b0; seletor_ulaB = 2'b00;
    ShiftOP = 3'b000; SrInputSrc = 1'b0; SrNSrc = 2'b00;
    RegDst = 3'b000; MemtoReg = 4'b0000; PCSource = 2'b00; IorD = 2'b00;
    case (state_q)
      S_RST: state_d = S_F1;
      S_F1, S_F2, S_F3: begin
        seletor_ulaB = 2'b01;
        Seletor = 3'b001;
        IRWrite = state_q == S_F3;
        PC_write = state_q == S_F3;
        state_d = state_q == S_F1 ? S_F2 : state_q == S_F2 ? S_F3 : S_DEC;
      end
      S_DEC: begin
        A_write = 1'b1;
        B_write = 1'b1;
        state_d = (is_sll | is_srl | is_sra) ? S_SH1 : (is_beq | is_bne) ? S_BR1 :
                  is_lw ? S_LW1 : is_sw ? S_SW : is_exec ? S_EXEC : S_EXC1;
        cause_d = (is_sll | is_srl | is_sra | is_beq | is_bne | is_lw | is_sw | is_exec) ? cause_q : 1'b0;
      end
      S_EXEC: begin
        seletor_ulaA = is_add | is_sub | is_and | is_slt | is_jr | is_addi;
        seletor_ulaB = is_addi ? 2'b10 : 2'b00;
        Seletor = (is_add | is_addi) ? 3'b001 : is_sub ? 3'b010 : is_and ? 3'b011 :
                  is_slt ? 3'b111 : 3'b000;
        RegDst = (is_add | is_sub | is_and | is_slt | is_mfhi | is_mflo) ? 3'b001 :
                 is_jal ? 3'b010 : 3'b000;
        MemtoReg = is_slt ? 4'b0110 : is_mfhi ? 4'b0010 : is_mflo ? 4'b0011 :
                   is_lui ? 4'b0101 : is_jal ? 4'b0111 : 4'b0000;
        RegWrite = !trap && !(is_jr | is_j);
        PC_write = is_jr | is_j | is_jal;
        PCSource = (is_j | is_jal) ? 2'b01 : 2'b00;
        state_d = trap ? S_EXC1 : S_F1;
        cause_d = trap ? 1'b1 : cause_q;
      end
      S_SH1: begin
        ShiftOP = 3'b001;
        state_d = S_SH2;
      end
      S_SH2: begin
        ShiftOP = is_sll ? 3'b010 : is_srl ? 3'b011 : 3'b100;
        state_d = S_SH3;
      end
      S_SH3: begin
        RegWrite = 1'b1;
        RegDst = 3'b001;
        MemtoReg = 4'b0100;
        state_d = S_F1;
      end
      S_BR1: begin
        seletor_ulaA = 1'b1;
        Seletor = 3'b111;
        FlagRegWrite = 1'b1;
        state_d = S_BR2;
      end
      S_BR2: begin
        seletor_ulaB = 2'b11;
        Seletor = 3'b001;
        PC_write = is_beq ? flag_eq : !flag_eq;
        state_d = S_F1;
      end
      S_LW1, S_LW2, S_LW3, S_SW: begin
        seletor_ulaA = 1'b1;
        seletor_ulaB = 2'b10;
        Seletor = 3'b001;
        IorD = 2'b01;
        MemWrite = state_q == S_SW;
        RegWrite = state_q == S_LW3;
        MemtoReg = state_q == S_LW3 ? 4'b0001 : 4'b0000;
        state_d = state_q == S_LW1 ? S_LW2 : state_q == S_LW2 ? S_LW3 : S_F1;
      end
      S_EXC1: begin
        seletor_ulaB = 2'b01;
        Seletor = 3'b010;
        EPC_write = 1'b1;
        IorD = {1'b1, cause_q};
        state_d = S_EXC2;
      end
      S_EXC2: begin
        IorD = {1'b1, cause_q};
        state_d = S_EXC3;
      end
      S_EXC3: begin
        IorD = {1'b1, cause_q};
        PCSource = 2'b10;
        PC_write = 1'b1;
        state_d = S_F1;
      end
      default: state_d = S_RST;
    endcase
    if (!reset) begin
      PC_write = 1'b0; A_write = 1'b0; B_write = 1'b0; EPC_write = 1'b0;
      HI_write = 1'b0; LO_write = 1'b0; FlagRegWrite = 1'b0; IRWrite = 1'b0;
      RegWrite = 1'b0; MemWrite = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RST;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end
endmodule
